// File: rtl/seq_detector_param_pkg.sv
// Shared constants for the parametrised sequence detector: overlap mode
// encodings and the legal parameter ranges checked at elaboration.
package seq_detector_param_pkg;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;
  localparam int CNT_W_MIN   = 1;
  localparam int CNT_W_MAX   = 16;

  function automatic bit in_range(input int val, input int lo, input int hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/seq_detector_param_window.sv
// Sliding window of accepted bits with fill tracking and Mealy match.
// state   | meaning
// EMPTY   | fill = 0, no valid history
// FILLING | 0 < fill < PAT_LEN
// ARMED   | fill = PAT_LEN, every accepted bit can complete a match
module seq_window
  import seq_detector_param_pkg::*;
#(
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic bit_en,
  input  logic clr,
  input  logic mode,
  output logic match,
  output logic empty,
  output logic armed
);

  localparam int                FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_LEN);

  if (!in_range(PAT_LEN, PAT_LEN_MIN, PAT_LEN_MAX)) begin : g_bad_pat_len
    $error("seq_window: PAT_LEN %0d outside %0d..%0d", PAT_LEN, PAT_LEN_MIN, PAT_LEN_MAX);
  end

  logic [PAT_LEN-1:0] hist, hist_n;
  logic [FILL_W-1:0]  fill, fill_n;

  always_comb begin
    hist_n = {hist[PAT_LEN-2:0], d};
    fill_n = (fill == FULL) ? FULL : fill + FILL_W'(1);
    match  = bit_en & ~clr & (fill_n == FULL) & (hist_n == PATTERN);
  end

  assign empty = (fill == '0);
  assign armed = (fill == FULL);

  // Non-overlapping hits restart the window so the next hit needs fresh bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (bit_en) begin
      hist <= hist_n;
      fill <= (match && (mode != MODE_OVL)) ? '0 : fill_n;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: registered hit pulse, saturating hit counter,
// run-time overlap selection and synchronous clear.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = '0,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             D,
  input  logic             bit_en,
  input  logic             overlap,
  input  logic             clr,
  output logic             Q,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             cnt_sat
);

  if (!in_range(CNT_W, CNT_W_MIN, CNT_W_MAX)) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W %0d outside %0d..%0d", CNT_W, CNT_W_MIN, CNT_W_MAX);
  end

  logic             mode;
  logic             match;
  logic             win_empty;
  logic             win_armed;
  logic [CNT_W-1:0] cnt_next;

  assign mode = overlap ? MODE_OVL : MODE_NONOVL;

  seq_window #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_window (
    .clk    (clk),
    .rst_n  (_rst),
    .d      (D),
    .bit_en (bit_en),
    .clr    (clr),
    .mode   (mode),
    .match  (match),
    .empty  (win_empty),
    .armed  (win_armed)
  );

  // cnt_sat mirrors the stored count, so it also gates further increments.
  assign cnt_next = (match && !cnt_sat) ? hit_cnt + CNT_W'(1) : hit_cnt;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      Q       <= 1'b0;
      hit_cnt <= '0;
      cnt_sat <= 1'b0;
    end else if (clr) begin
      Q       <= 1'b0;
      hit_cnt <= '0;
      cnt_sat <= 1'b0;
    end else begin
      Q       <= match;
      hit_cnt <= cnt_next;
      cnt_sat <= &cnt_next;
    end
  end

`ifndef SYNTHESIS
  string win_status;
  always_comb begin
    win_status = "FILLING";
    if (win_empty)      win_status = "EMPTY";
    else if (win_armed) win_status = "ARMED";
    assert (win_status.len() > 0);
  end
`endif

endmodule
